// File: rtl/accel_window_filter.sv
// accel_window_filter: per-channel sliding-window filter with bypass, moving-average and decimating-average modes
//   clk, reset        : single clock, synchronous active-high reset
//   mode              : 00/11 bypass, 01 moving average, 10 decimating average
//   clear             : flush window state (no sample accepted that cycle)
//   in_valid/in_ready : input handshake, in_data packs channel k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready: single-entry output register handshake, out_data packed like in_data
//   sample_count      : accepted sample sets since reset/clear/mode change, saturating
module accel_window_filter #(
    parameter int CHANNELS   = 3,
    parameter int DATA_W     = 31,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    output logic [15:0]                sample_count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int ACC_W = DATA_W + DEPTH_LOG2;

    typedef enum logic {FILL, RUN} state_t;

    state_t                  state, state_base, state_nx;
    logic [1:0]              mode_q;
    logic [DEPTH_LOG2-1:0]   ptr, ptr_base;
    logic [DATA_W-1:0]       mem [CHANNELS][DEPTH];
    logic [ACC_W-1:0]        sum [CHANNELS];
    logic [ACC_W-1:0]        sum_nx [CHANNELS];
    logic [ACC_W-1:0]        old_v [CHANNELS];
    logic [ACC_W-1:0]        new_v [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] avg;
    logic [15:0]             cnt_base;
    logic                    mode_chg, accept, last, emit, averaging;

    // A mode change flushes the window in the same cycle it is seen, so an
    // accept in that cycle becomes the first sample of the fresh window.
    assign mode_chg   = mode != mode_q;
    assign in_ready   = !clear && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign state_base = mode_chg ? FILL : state;
    assign ptr_base   = mode_chg ? '0 : ptr;
    assign cnt_base   = mode_chg ? '0 : sample_count;
    assign averaging  = mode == 2'b01 || mode == 2'b10;
    // The write pointer doubles as fill count and decimation phase: all three
    // restart together and advance once per accept.
    assign last       = ptr_base == '1;
    assign emit       = accept && (mode == 2'b01 ? (state_base == RUN || last) :
                                   mode == 2'b10 ? last : 1'b1);

    always_comb begin
        avg = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            new_v[c]  = {{DEPTH_LOG2{in_data[c*DATA_W+DATA_W-1]}}, in_data[c*DATA_W +: DATA_W]};
            old_v[c]  = state_base == RUN ? {{DEPTH_LOG2{mem[c][ptr_base][DATA_W-1]}}, mem[c][ptr_base]} : '0;
            sum_nx[c] = (mode_chg ? '0 : sum[c]) - old_v[c] + new_v[c];
            // Dropping the low DEPTH_LOG2 bits is an arithmetic shift with floor.
            avg[c*DATA_W +: DATA_W] = sum_nx[c][ACC_W-1:DEPTH_LOG2];
        end
    end

    always_comb begin
        state_nx = state_base;
        if (clear)
            state_nx = FILL;
        else if (accept && state_base == FILL && last)
            state_nx = RUN;
    end

    always_ff @(posedge clk) begin
        if (accept)
            for (int c = 0; c < CHANNELS; c++)
                mem[c][ptr_base] <= in_data[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            mode_q       <= mode;
            ptr          <= '0;
            sample_count <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            for (int c = 0; c < CHANNELS; c++)
                sum[c] <= '0;
        end else begin
            state  <= state_nx;
            mode_q <= mode;
            if (clear || (mode_chg && !accept)) begin
                ptr          <= '0;
                sample_count <= '0;
                for (int c = 0; c < CHANNELS; c++)
                    sum[c] <= '0;
            end else if (accept) begin
                ptr          <= ptr_base + 1'b1;
                sample_count <= cnt_base + 16'(cnt_base != 16'hffff);
                for (int c = 0; c < CHANNELS; c++)
                    sum[c] <= sum_nx[c];
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= averaging ? avg : in_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_accel_window_filter.sv
// tb_accel_window_filter: directed self-checking bench for accel_window_filter (DEPTH_LOG2=2)
module tb_accel_window_filter;
    localparam int CH = 3;
    localparam int DW = 31;
    localparam int W  = CH * DW;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   mode;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [15:0]  sample_count;

    int checks = 0;
    int errors = 0;

    accel_window_filter #(.CHANNELS(CH), .DATA_W(DW), .DEPTH_LOG2(2)) dut (
        .clk(clk), .reset(reset), .mode(mode), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input int ch, input logic [DW-1:0] v);
        logic [W-1:0] r;
        r = '0;
        r[ch*DW +: DW] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [DW-1:0] v);
        in_data  = pack(ch, v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        if (sample_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sample_count); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_moving_avg();
        logic [DW-1:0] vals [5] = '{31'd4, 31'd8, 31'd12, 31'd16, 31'd20};
        for (int i = 0; i < 3; i++) begin
            send(0, vals[i]);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mavg_fill_%0d out_valid got %0b want 0", i, out_valid); end
        end
        send(0, vals[3]);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mavg_first_valid got %0b want 1", out_valid); end
        if (out_data !== pack(0, 31'd10)) begin errors++; $display("FAIL mavg_first_data got %h want %h", out_data, pack(0, 31'd10)); end
        send(0, vals[4]);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mavg_second_valid got %0b want 1", out_valid); end
        if (out_data !== pack(0, 31'd14)) begin errors++; $display("FAIL mavg_second_data got %h want %h", out_data, pack(0, 31'd14)); end
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mavg_drained got %0b want 0", out_valid); end
        if (sample_count !== 16'd5) begin errors++; $display("FAIL mavg_count got %0d want 5", sample_count); end
    endtask

    task automatic test_floor();
        logic [DW-1:0] neg1 = -31'sd1;
        logic [DW-1:0] neg2 = -31'sd2;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(1, neg1);
        for (int i = 0; i < 2; i++) begin
            send(1, neg2);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL floor_fill_%0d out_valid got %0b want 0", i, out_valid); end
        end
        send(1, neg2);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL floor_valid got %0b want 1", out_valid); end
        if (out_data !== pack(1, 31'h7ffffffe)) begin errors++; $display("FAIL floor_data got %h want %h", out_data, pack(1, 31'h7ffffffe)); end
        if (sample_count !== 16'd4) begin errors++; $display("FAIL floor_count got %0d want 4", sample_count); end
        tick();
    endtask

    task automatic test_decimate();
        int n = 0;
        logic [W-1:0] got [2];
        got[0] = '0;
        got[1] = '0;
        set_mode(2'b10);
        for (int i = 1; i <= 8; i++) begin
            send(2, 31'(i));
            if (out_valid) begin
                if (n < 2) got[n] = out_data;
                n++;
            end
        end
        tick();
        checks += 3;
        if (n != 2) begin errors++; $display("FAIL dec_count got %0d want 2", n); end
        if (got[0] !== pack(2, 31'd2)) begin errors++; $display("FAIL dec_first got %h want %h", got[0], pack(2, 31'd2)); end
        if (got[1] !== pack(2, 31'd6)) begin errors++; $display("FAIL dec_second got %h want %h", got[1], pack(2, 31'd6)); end
    endtask

    task automatic test_backpressure();
        set_mode(2'b00);
        out_ready = 1'b0;
        send(0, 31'h55);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pack(0, 31'h55)) begin errors++; $display("FAIL bp_load got %0b/%h want 1/%h", out_valid, out_data, pack(0, 31'h55)); end
        in_data  = pack(0, 31'h66);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks += 2;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d got %0b want 0", i, in_ready); end
            if (out_valid !== 1'b1 || out_data !== pack(0, 31'h55)) begin errors++; $display("FAIL bp_hold_%0d got %0b/%h want 1/%h", i, out_valid, out_data, pack(0, 31'h55)); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b1 || out_data !== pack(0, 31'h66)) begin errors++; $display("FAIL bp_new_data got %0b/%h want 1/%h", out_valid, out_data, pack(0, 31'h66)); end
        if (sample_count !== 16'd2) begin errors++; $display("FAIL bp_count got %0d want 2", sample_count); end
        tick();
    endtask

    task automatic test_clear();
        set_mode(2'b01);
        send(0, 31'd100);
        send(0, 31'd100);
        clear    = 1'b1;
        in_data  = pack(0, 31'd100);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %0b want 0", in_ready); end
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (sample_count !== 16'd0) begin errors++; $display("FAIL clr_count got %0d want 0", sample_count); end
        for (int i = 1; i <= 3; i++) begin
            send(0, 31'(i));
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_fill_%0d out_valid got %0b want 0", i, out_valid); end
        end
        send(0, 31'd4);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pack(0, 31'd2)) begin errors++; $display("FAIL clr_out got %0b/%h want 1/%h", out_valid, out_data, pack(0, 31'd2)); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(0, 31'd40);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b want 0", out_valid); end
        if (sample_count !== 16'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", sample_count); end
        for (int i = 0; i < 3; i++) begin
            send(0, 31'd8);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_fill_%0d out_valid got %0b want 0", i, out_valid); end
        end
        send(0, 31'd8);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pack(0, 31'd8)) begin errors++; $display("FAIL rmid_out got %0b/%h want 1/%h", out_valid, out_data, pack(0, 31'd8)); end
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 2'b01;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        test_reset();
        test_moving_avg();
        test_floor();
        test_decimate();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
